writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/rv32i_types.sv | 38 +++
 rtl/wb_md_fifo.sv | 62 ++++++
 rtl/writeback_stage.sv | 88 ++++++++
 tb/tb_writeback_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared writeback types and load formatting helper
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } md_entry_t;

    // Extract the addressed byte/half from an aligned word and extend it.
    function automatic logic [31:0] format_load(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  addr_lo
    );
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = word >> {addr_lo, 3'b000};
        half_sh = word >> {addr_lo[1], 4'b0000};
        case (funct3)
            lb:      res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            lh:      res = {{16{half_sh[15]}}, half_sh[15:0]};
            lbu:     res = {24'd0, byte_sh[7:0]};
            lhu:     res = {16'd0, half_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// rtl/wb_md_fifo.sv - MUL/DIV result holding queue with per-entry visibility
module wb_md_fifo
    import rv32i_types::*;
#(
    parameter int MD_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  md_entry_t                     push_entry,
    input  logic                          pop,
    output md_entry_t                     head,
    output logic [$clog2(MD_DEPTH):0]     count,
    output logic [MD_DEPTH-1:0]           entry_valid,
    output logic [MD_DEPTH-1:0][4:0]      entry_rd
);

    localparam int PW = $clog2(MD_DEPTH);

    md_entry_t     mem [MD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
            for (int i = 0; i < MD_DEPTH; i++) begin
                if (push && wr_ptr == PW'(i))
                    entry_valid[i] <= 1'b1;
                else if (pop && rd_ptr == PW'(i))
                    entry_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        for (int i = 0; i < MD_DEPTH; i++)
            entry_rd[i] = mem[i].rd;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - register-file write port arbitration between pipeline and MUL/DIV queue
module writeback_stage
    import rv32i_types::*;
#(
    parameter int MD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_is_load,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_mem_rdata,
    input  logic [2:0]  wb_funct3,
    input  logic [1:0]  wb_addr_lo,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        md_ready,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_in,
    output logic [31:0] md_pending
);

    localparam int CW = $clog2(MD_DEPTH) + 1;

    logic                     pipe_claim;
    logic                     q_push;
    logic                     q_pop;
    logic                     q_empty;
    md_entry_t                q_head;
    md_entry_t                q_in;
    logic [CW-1:0]            q_count;
    logic [MD_DEPTH-1:0]      q_valid;
    logic [MD_DEPTH-1:0][4:0] q_rd;

    assign pipe_claim = wb_valid && (wb_rd != 5'd0);
    // Registered count only, so md_ready has no path from md_valid or wb_valid.
    assign md_ready   = (q_count != CW'(MD_DEPTH));
    assign q_empty    = (q_count == '0);
    assign q_push     = md_valid && md_ready && (md_rd != 5'd0);
    assign q_pop      = !pipe_claim && !q_empty;
    assign q_in       = '{rd: md_rd, result: md_result};

    wb_md_fifo #(
        .MD_DEPTH (MD_DEPTH)
    ) u_md_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (q_push),
        .push_entry  (q_in),
        .pop         (q_pop),
        .head        (q_head),
        .count       (q_count),
        .entry_valid (q_valid),
        .entry_rd    (q_rd)
    );

    always_comb begin
        md_pending = '0;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (q_valid[i])
                md_pending[q_rd[i]] = 1'b1;
        end
        md_pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_load <= 1'b0;
            rf_dest <= '0;
            rf_in   <= '0;
        end else if (pipe_claim) begin
            rf_load <= 1'b1;
            rf_dest <= wb_rd;
            rf_in   <= wb_is_load ? format_load(wb_mem_rdata, wb_funct3, wb_addr_lo)
                                  : wb_alu_result;
        end else if (q_pop) begin
            rf_load <= 1'b1;
            rf_dest <= q_head.rd;
            rf_in   <= q_head.result;
        end else begin
            rf_load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
    import rv32i_types::*;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        wb_is_load = 1'b0;
    logic [31:0] wb_alu_result = '0;
    logic [31:0] wb_mem_rdata = '0;
    logic [2:0]  wb_funct3 = '0;
    logic [1:0]  wb_addr_lo = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_result = '0;
    logic        md_ready;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [31:0] md_pending;

    writeback_stage #(.MD_DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_is_load    (wb_is_load),
        .wb_alu_result (wb_alu_result),
        .wb_mem_rdata  (wb_mem_rdata),
        .wb_funct3     (wb_funct3),
        .wb_addr_lo    (wb_addr_lo),
        .md_valid      (md_valid),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .md_ready      (md_ready),
        .rf_load       (rf_load),
        .rf_dest       (rf_dest),
        .rf_in         (rf_in),
        .md_pending    (md_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    md_entry_t   q[$];
    logic        m_load = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [31:0] m_in = '0;
    logic [4:0]  order[$];

    function automatic logic [31:0] ref_fmt(logic [31:0] w, logic [2:0] f, logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("md_ready", 32'(md_ready), 32'(q.size() < D));
        check("md_pending", md_pending, ref_pending());
        check("rf_load", 32'(rf_load), 32'(m_load));
        check("rf_dest", 32'(rf_dest), 32'(m_dest));
        check("rf_in", rf_in, m_in);
    endtask

    task automatic cycle();
        bit        push;
        md_entry_t e;
        push = md_valid && (q.size() < D) && (md_rd != 5'd0);
        if (wb_valid && wb_rd != 5'd0) begin
            m_load = 1'b1;
            m_dest = wb_rd;
            m_in   = wb_is_load ? ref_fmt(wb_mem_rdata, wb_funct3, wb_addr_lo) : wb_alu_result;
        end else if (q.size() > 0) begin
            e      = q.pop_front();
            m_load = 1'b1;
            m_dest = e.rd;
            m_in   = e.result;
        end else begin
            m_load = 1'b0;
        end
        if (push) begin
            e.rd     = md_rd;
            e.result = md_result;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (rf_load) order.push_back(rf_dest);
    endtask

    task automatic set_load(logic [2:0] f, logic [1:0] a, logic [4:0] rd, logic [31:0] w);
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_funct3 = f; wb_addr_lo = a;
        wb_rd = rd; wb_mem_rdata = w;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check_all();
        check("reset_ready", 32'(md_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // load formatting
        set_load(3'b000, 2'd3, 5'd5, 32'h80FF7F01);
        cycle();
        check("lb_data", rf_in, 32'hFFFFFF80);
        check("lb_dest", 32'(rf_dest), 32'd5);
        set_load(3'b100, 2'd3, 5'd5, 32'h80FF7F01);
        cycle();
        check("lbu_data", rf_in, 32'h00000080);
        set_load(3'b101, 2'd2, 5'd5, 32'h80FF7F01);
        cycle();
        check("lhu_data", rf_in, 32'h000080FF);
        set_load(3'b001, 2'd0, 5'd6, 32'h80FF7F01);
        cycle();
        check("lh_data", rf_in, 32'h00007F01);

        // queued result waits behind continuous pipeline writes
        wb_is_load = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_alu_result = 32'hCAFE0003;
        md_valid = 1'b1; md_rd = 5'd7; md_result = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            cycle();
            md_valid = 1'b0;
            check("q_pend7", 32'(md_pending[7]), 32'd1);
            check("q_pipe_dest", 32'(rf_dest), 32'd3);
        end
        wb_valid = 1'b0;
        cycle();
        check("q_drain_dest", 32'(rf_dest), 32'd7);
        check("q_drain_data", rf_in, 32'h1234);
        check("q_pend7_clr", 32'(md_pending[7]), 32'd0);

        // backpressure at depth 2, third result held by producer
        wb_valid = 1'b1; wb_rd = 5'd3;
        md_valid = 1'b1; md_rd = 5'd10; md_result = 32'hA0;
        cycle();
        md_rd = 5'd11; md_result = 32'hA1;
        cycle();
        check("bp_ready_low", 32'(md_ready), 32'd0);
        md_rd = 5'd12; md_result = 32'hA2;
        cycle();
        cycle();
        wb_valid = 1'b0;
        order.delete();
        for (int t = 0; t < 8; t++) begin
            logic acc;
            acc = md_valid && md_ready;
            cycle();
            if (acc) md_valid = 1'b0;
        end
        check("bp_count", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            check("bp_order0", 32'(order[0]), 32'd10);
            check("bp_order1", 32'(order[1]), 32'd11);
            check("bp_order2", 32'(order[2]), 32'd12);
        end

        // rd 0 on either side
        wb_valid = 1'b1; wb_rd = 5'd3; md_valid = 1'b1; md_rd = 5'd20; md_result = 32'hBEEF;
        cycle();
        md_valid = 1'b0; wb_rd = 5'd0;
        cycle();
        check("rd0_pipe_dest", 32'(rf_dest), 32'd20);
        check("rd0_pipe_data", rf_in, 32'hBEEF);
        wb_valid = 1'b0; md_valid = 1'b1; md_rd = 5'd0; md_result = 32'h5555;
        cycle();
        md_valid = 1'b0;
        check("rd0_md_noload", 32'(rf_load), 32'd0);
        check("rd0_md_pend", md_pending, 32'd0);
        cycle();
        check("rd0_md_noload2", 32'(rf_load), 32'd0);

        // randomized traffic, repeated rd values to exercise shared pending bits
        for (int t = 0; t < 400; t++) begin
            wb_valid      = ($urandom_range(0, 99) < 55);
            wb_rd         = 5'($urandom_range(0, 31));
            wb_is_load    = 1'($urandom_range(0, 1));
            wb_alu_result = $urandom;
            wb_mem_rdata  = $urandom;
            wb_funct3     = 3'($urandom_range(0, 7));
            wb_addr_lo    = 2'($urandom_range(0, 3));
            md_valid      = 1'($urandom_range(0, 1));
            md_rd         = 5'($urandom_range(0, 7));
            md_result     = $urandom;
            cycle();
        end

        // asynchronous reset with queue full and a write in flight
        wb_valid = 1'b1; wb_rd = 5'd4; wb_is_load = 1'b0; wb_alu_result = 32'h44;
        while (q.size() > 0) begin
            md_valid = 1'b0;
            wb_valid = 1'b0;
            cycle();
        end
        wb_valid = 1'b1;
        md_valid = 1'b1; md_rd = 5'd21; md_result = 32'h21;
        cycle();
        md_rd = 5'd22; md_result = 32'h22;
        cycle();
        md_valid = 1'b0;
        cycle();
        check("rst_pre_q", 32'(q.size()), 32'd2);
        check("rst_pre_load", 32'(rf_load), 32'd1);
        wb_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_load = 1'b0; m_dest = '0; m_in = '0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cycle();
            check("rst_no_replay", 32'(rf_load), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
